// File: rtl/i2s_tx_serializer_pkg.sv
// Shared audio constants for the I2S transmit path: sample width selection,
// slot width and bit-counter sizing.
package i2s_tx_serializer_pkg;

  typedef enum int {
    AUDIO_W_16 = 16,
    AUDIO_W_24 = 24,
    AUDIO_W_32 = 32
  } audio_width_e;

  localparam audio_width_e SAMPLE_W_SEL = AUDIO_W_24;
  localparam int SAMPLE_W_DEF = int'(SAMPLE_W_SEL);
  localparam int SLOT_W_DEF   = 32;

  // Bit counter spans both slots of a stereo frame.
  function automatic int bit_cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(SLOT_W_DEF);

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock and word-clock timing: half-period counter, frame bit counter,
// BCLK/LRCK generation and the fall-tick / frame-load strobes.
module i2s_bclk_gen
  import i2s_tx_serializer_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SLOT_W   = SLOT_W_DEF
) (
  input  logic                         OSC_CLK,
  input  logic                         reset_reg,
  output logic                         bclk,
  output logic                         lrck,
  output logic                         fall_tick,
  output logic                         frame_load,
  output logic [bit_cnt_w(SLOT_W)-1:0] bit_nxt
);

  localparam int CW  = bit_cnt_w(SLOT_W);
  localparam int LB  = $clog2(SLOT_W);
  localparam int HPW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [HPW-1:0] hp_cnt;
  logic [CW-1:0]  bit_cnt;
  logic           hp_tc;
  logic           bit_wrap;

  assign hp_tc      = (hp_cnt == HPW'(BCLK_DIV - 1));
  assign fall_tick  = hp_tc & bclk;
  assign bit_wrap   = (bit_cnt == CW'(2 * SLOT_W - 1));
  assign bit_nxt    = bit_wrap ? '0 : bit_cnt + 1'b1;
  assign frame_load = fall_tick & bit_wrap;

  // Bit counter parks at the last position so the first fall tick loads a frame.
  always_ff @(posedge OSC_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      hp_cnt  <= '0;
      bclk    <= 1'b0;
      bit_cnt <= CW'(2 * SLOT_W - 1);
      lrck    <= 1'b0;
    end else begin
      if (hp_tc) begin
        hp_cnt <= '0;
        bclk   <= ~bclk;
      end else begin
        hp_cnt <= hp_cnt + 1'b1;
      end
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrck    <= bit_nxt[LB];
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter with a one-frame holding buffer and sticky underrun.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BCLK_DIV = 4,
  parameter int SLOT_W   = SLOT_W_DEF
) (
  input  logic                OSC_CLK,
  input  logic                reset_reg,
  input  logic [SAMPLE_W-1:0] lsound_in,
  input  logic [SAMPLE_W-1:0] rsound_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                clear_underrun,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                underrun
);

  localparam int CW = bit_cnt_w(SLOT_W);
  localparam int LB = $clog2(SLOT_W);

  logic                fall_tick;
  logic                frame_load;
  logic [CW-1:0]       bit_nxt;
  logic [SAMPLE_W-1:0] buf_l, buf_r;
  logic [SAMPLE_W-1:0] sh_l, sh_r;
  logic [SAMPLE_W-1:0] nxt_l, nxt_r;
  logic [SAMPLE_W-1:0] word;
  logic                buf_full;
  logic                capture;
  logic [LB-1:0]       pos;
  logic                dat_nxt;

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV),
    .SLOT_W  (SLOT_W)
  ) u_bclk_gen (
    .OSC_CLK   (OSC_CLK),
    .reset_reg (reset_reg),
    .bclk      (AUD_BCLK),
    .lrck      (AUD_DACLRCK),
    .fall_tick (fall_tick),
    .frame_load(frame_load),
    .bit_nxt   (bit_nxt)
  );

  assign sample_ready = ~buf_full;
  assign capture      = sample_valid & ~buf_full;

  // Frame being started: fresh buffer contents if available, else replay.
  assign nxt_l = (frame_load & buf_full) ? buf_l : sh_l;
  assign nxt_r = (frame_load & buf_full) ? buf_r : sh_r;
  assign pos   = bit_nxt[LB-1:0];

  always_comb begin
    word    = bit_nxt[LB] ? nxt_r : nxt_l;
    dat_nxt = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      if (int'(pos) == SAMPLE_W - 1 - i) dat_nxt = word[i];
`else
      if (int'(pos) == SAMPLE_W - i) dat_nxt = word[i];
`endif
    end
  end

  always_ff @(posedge OSC_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      buf_l      <= '0;
      buf_r      <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      buf_full   <= 1'b0;
      underrun   <= 1'b0;
      AUD_DACDAT <= 1'b0;
    end else begin
      if (capture) begin
        buf_l <= lsound_in;
        buf_r <= rsound_in;
      end
      // A capture can only happen into an empty buffer, so it always wins.
      if (capture)         buf_full <= 1'b1;
      else if (frame_load) buf_full <= 1'b0;
      if (frame_load) begin
        sh_l <= nxt_l;
        sh_r <= nxt_r;
      end
      if (frame_load && !buf_full) underrun <= 1'b1;
      else if (clear_underrun)     underrun <= 1'b0;
      if (fall_tick) AUD_DACDAT <= dat_nxt;
    end
  end

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 24, giving the sample width in bits; legal values are 16, 24 and 32.
REQ-002 The block SHALL have parameter BCLK_DIV, default 4, giving OSC_CLK cycles per BCLK half-period; the minimum is 1.
REQ-003 The block SHALL have parameter SLOT_W, default 32, giving BCLK periods per channel slot; it SHALL be at least SAMPLE_W+1.
REQ-004 Port OSC_CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_reg  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 Port lsound_in  input  SAMPLE_W  SHALL carry the left sample, two's complement.
REQ-007 Port rsound_in  input  SAMPLE_W  SHALL carry the right sample, two's complement.
REQ-008 Port sample_valid  input  1  SHALL mark that lsound_in/rsound_in hold a stereo frame.
REQ-009 Port sample_ready  output  1  SHALL be high when the holding buffer is empty.
REQ-010 Port clear_underrun  input  1  SHALL clear the underrun flag.
REQ-011 Port AUD_BCLK  output  1  SHALL be the bit clock.
REQ-012 Port AUD_DACLRCK  output  1  SHALL be the word clock: 0 = left slot, 1 = right slot.
REQ-013 Port AUD_DACDAT  output  1  SHALL be the serial data.
REQ-014 Port underrun  output  1  SHALL be a sticky underrun flag.

Function
REQ-015 A half-period counter SHALL count 0..BCLK_DIV-1 and toggle AUD_BCLK on terminal count; the OSC_CLK cycle in which AUD_BCLK goes 1->0 is the "fall tick".
REQ-016 A bit counter, range 0..2*SLOT_W-1, SHALL advance only on fall ticks and wrap from 2*SLOT_W-1 to 0.
REQ-017 AUD_DACLRCK SHALL equal bit counter bit log2(SLOT_W), updated on the fall tick.
REQ-018 In I2S mode the slot MSB SHALL appear on AUD_DACDAT at slot bit position 1, one BCLK after the LRCK edge, followed by the remaining bits MSB-first.
REQ-019 Slot positions outside the sample bits SHALL drive 0.
REQ-020 AUD_DACDAT and AUD_DACLRCK SHALL change only on fall ticks so that they are stable on BCLK rising edges.
REQ-021 Handshake: when sample_valid and sample_ready are both high in a cycle, both samples SHALL be captured into the holding buffer and sample_ready SHALL go low in the next cycle.
REQ-022 Frame load: on the fall tick where the bit counter wraps to 0, the shift registers SHALL load from the holding buffer if it is full, and the buffer SHALL be marked empty (sample_ready goes high in the next cycle).
REQ-023 If the holding buffer is empty at a frame load, the previous frame SHALL be replayed and underrun SHALL be set.
REQ-024 If a capture and a frame load occur in the same cycle, the load SHALL use the old buffer contents if full; otherwise underrun SHALL be set. The captured data SHALL remain in the buffer, and the buffer SHALL stay full.
REQ-025 If clear_underrun and an underrun event occur in the same cycle, set SHALL win.
REQ-026 Latency: a frame accepted at least one cycle before frame load N SHALL be output starting in frame N.

Reset
REQ-027 While reset_reg is high, the outputs SHALL be AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, sample_ready=1 and underrun=0.
REQ-028 While reset_reg is high, the shift registers and holding buffer SHALL be 0 and the buffer empty.
REQ-029 While reset_reg is high, the half-period counter SHALL be 0 and the bit counter 2*SLOT_W-1, so the first fall tick after release is a frame load.
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately; no partial bits SHALL be emitted after release.

Configuration
REQ-031 With I2S_TX_LEFT_JUSTIFIED_EN defined, the MSB SHALL appear at slot position 0, coincident with the LRCK edge.
REQ-032 With I2S_TX_LEFT_JUSTIFIED_EN undefined, standard I2S one-bit delay SHALL apply as in REQ-018.

Structure
REQ-033 The audio package SHALL hold the SAMPLE_W selection (16/24/32, matching the synth audio-width options), SLOT_W and a clog2-based BIT_CNT_W constant.
REQ-034 One sub-module, i2s_bclk_gen (half-period and bit counters, BCLK, LRCK, fall-tick strobe), SHALL be instantiated; the datapath SHALL stay in the top module.

Verification
REQ-035 With SAMPLE_W=16, SLOT_W=32, BCLK_DIV=2, loading L=16'hA5C3 and R=16'h0001 SHALL produce left slot bits 1..16 = 1010010111000011 and the other left slot bits 0, and a right slot with a 1 only at position 16.
REQ-036 The BCLK period SHALL be 4 OSC_CLK cycles, the LRCK period 256 cycles, and DACDAT/LRCK transitions SHALL occur only in fall-tick cycles.
REQ-037 If no sample_valid is given after the first frame (L=16'h1234), the second frame SHALL replay 16'h1234 and underrun SHALL go to 1; pulsing clear_underrun SHALL return it to 0.
REQ-038 With sample_valid asserted in the exact fall-tick cycle of a frame load while the buffer is empty, underrun SHALL be 1, the new frame SHALL appear in the following frame, and sample_ready SHALL stay 0 until that frame's load.
REQ-039 Asserting reset_reg at bit counter 20 SHALL drive all outputs to reset values that cycle, and the first post-reset frame SHALL start at a clean LRCK falling edge.
REQ-040 With I2S_TX_LEFT_JUSTIFIED_EN defined, L=16'h8000 SHALL produce a 1 at slot position 0 and nowhere else in the left slot.
